// File: rtl/controlador_pkg.sv
// Shared encodings for the shift-register controller and the register's select mux.
package controlador_pkg;

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    CARREGA = 2'd1,
    DESLOCA = 2'd2,
    PAUSA   = 2'd3
  } estado_t;

  localparam logic [1:0] SEL_CARREGA = 2'b00;
  localparam logic [1:0] SEL_ESQ_DIR = 2'b01;
  localparam logic [1:0] SEL_DIR_ESQ = 2'b10;
  localparam logic [1:0] SEL_MANTER  = 2'b11;

  // Direction 0 travels toward bit 0, direction 1 toward bit N-1.
  function automatic logic [1:0] sel_deslocamento(input logic dir);
    return dir ? SEL_DIR_ESQ : SEL_ESQ_DIR;
  endfunction

endpackage

// File: rtl/controlador_deslocamento_divisor_tick.sv
// Shift-rate divider: registered one-cycle tick on each DIV-1 -> 0 wrap while enabled.
module divisor_tick #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] MAX = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] contagem;

  // A disabled counter keeps its value so a pause can resume mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contagem <= '0;
      tick     <= 1'b0;
    end else if (clear) begin
      contagem <= '0;
      tick     <= 1'b0;
    end else if (enable) begin
      if (contagem == MAX) begin
        contagem <= '0;
        tick     <= 1'b1;
      end else begin
        contagem <= contagem + DIV_W'(1);
        tick     <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/controlador_deslocamento.sv
// Sequencer for the bidirectional shift register's shared select lines {ch1,ch0}.
// Define AUTO_REVERSE_EN to latch direction on entry to DESLOCA and bounce at the register ends.
module controlador_deslocamento
  import controlador_pkg::*;
#(
  parameter int N   = 8,
  parameter int DIV = 25_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         botao_carregar,
  input  logic         botao_pausa,
  input  logic         habilitar,
  input  logic         direcao,
  input  logic [N-1:0] estado_registrador,
  output logic         ch1,
  output logic         ch0,
  output logic         tick,
  output logic         direcao_atual,
  output logic         pausado
);

  estado_t    estado, proximo;
  logic       carregar_ant, pausa_ant;
  logic       ev_carregar, ev_pausa;
  logic       entrando, habilita_div, limpa_div;
  logic       dir_q, dir_efetiva;
  logic [1:0] sel;
  logic       unused_estado;

  assign ev_carregar = botao_carregar & ~carregar_ant;
  assign ev_pausa    = botao_pausa & ~pausa_ant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carregar_ant <= 1'b0;
      pausa_ant    <= 1'b0;
    end else begin
      carregar_ant <= botao_carregar;
      pausa_ant    <= botao_pausa;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= PARADO;
    else        estado <= proximo;
  end

  // Priority: load event, then habilitar low, then pause event.
  always_comb begin
    proximo = estado;
    case (estado)
      PARADO: begin
        if (ev_carregar)    proximo = CARREGA;
        else if (habilitar) proximo = DESLOCA;
      end
      CARREGA: proximo = habilitar ? DESLOCA : PARADO;
      DESLOCA: begin
        if (ev_carregar)     proximo = CARREGA;
        else if (!habilitar) proximo = PARADO;
        else if (ev_pausa)   proximo = PAUSA;
      end
      PAUSA: begin
        if (ev_carregar)     proximo = CARREGA;
        else if (!habilitar) proximo = PARADO;
        else if (ev_pausa)   proximo = DESLOCA;
      end
      default: proximo = PARADO;
    endcase
  end

  always_comb begin
    sel     = SEL_MANTER;
    pausado = 1'b0;
    case (estado)
      CARREGA: sel = SEL_CARREGA;
      DESLOCA: if (tick) sel = sel_deslocamento(dir_efetiva);
      PAUSA:   pausado = 1'b1;
      default: sel = SEL_MANTER;
    endcase
  end

  assign {ch1, ch0}    = sel;
  assign direcao_atual = dir_efetiva;

  // Counting only when staying in DESLOCA means a wrap never lands on an exit edge,
  // so a tick that meets a load or pause event simply does not happen.
  assign entrando     = (proximo == DESLOCA) && (estado != DESLOCA);
  assign habilita_div = (estado == DESLOCA) && (proximo == DESLOCA);
  assign limpa_div    = entrando && (estado != PAUSA);

  divisor_tick #(.DIV(DIV)) u_divisor (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (habilita_div),
    .clear  (limpa_div),
    .tick   (tick)
  );

`ifdef AUTO_REVERSE_EN
  logic fim_zero, fim_topo;

  // End bits are registered; the register holds between ticks, so these match the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fim_zero <= 1'b0;
      fim_topo <= 1'b0;
    end else begin
      fim_zero <= estado_registrador[0];
      fim_topo <= estado_registrador[N-1];
    end
  end

  assign dir_efetiva = dir_q ^ (tick & (dir_q ? fim_topo : fim_zero));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        dir_q <= 1'b0;
    else if (entrando) dir_q <= direcao;
    else if (tick)     dir_q <= dir_efetiva;
  end
`else
  assign dir_efetiva = dir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= direcao;
  end
`endif

  assign unused_estado = ^estado_registrador;

endmodule

// File: tb/tb_controlador_deslocamento.sv
// Directed, scoreboard-checked bench for controlador_deslocamento with N=8, DIV=4.
// Define AUTO_REVERSE_EN for both DUT and bench to exercise the end-bounce mode.
module tb_controlador_deslocamento;

  localparam int N   = 8;
  localparam int DIV = 4;
`ifdef AUTO_REVERSE_EN
  localparam bit SEGUE = 1'b0;
`else
  localparam bit SEGUE = 1'b1;
`endif

  localparam logic [1:0] CARGA   = 2'b00;
  localparam logic [1:0] ESQ_DIR = 2'b01;
  localparam logic [1:0] DIR_ESQ = 2'b10;
  localparam logic [1:0] MANTER  = 2'b11;

  typedef struct {
    logic [4:0] valor;
    string      nome;
  } esperado_t;

  logic         clk;
  logic         rst_n;
  logic         botao_carregar;
  logic         botao_pausa;
  logic         habilitar;
  logic         direcao;
  logic [N-1:0] estado_registrador;
  logic         ch1, ch0, tick, direcao_atual, pausado;

  esperado_t fila[$];
  int        checks = 0;
  int        errors = 0;
  logic      dir_exp;

  controlador_deslocamento #(.N(N), .DIV(DIV)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .botao_carregar     (botao_carregar),
    .botao_pausa        (botao_pausa),
    .habilitar          (habilitar),
    .direcao            (direcao),
    .estado_registrador (estado_registrador),
    .ch1                (ch1),
    .ch0                (ch0),
    .tick               (tick),
    .direcao_atual      (direcao_atual),
    .pausado            (pausado)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] sel_tick(input logic d);
    return d ? DIR_ESQ : ESQ_DIR;
  endfunction

  task automatic comparar(input logic [4:0] esperado, input string nome);
    logic [4:0] obs;
    obs = {ch1, ch0, tick, pausado, direcao_atual};
    checks++;
    assert (obs === esperado) else begin
      errors++;
      $error("[TB] FAIL %s observed ch=%b tick=%b pausado=%b dir=%b expected ch=%b tick=%b pausado=%b dir=%b",
             nome, obs[4:3], obs[2], obs[1], obs[0],
             esperado[4:3], esperado[2], esperado[1], esperado[0]);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic p, input logic h, input logic d,
                               input logic [1:0] sel, input logic t, input logic pa,
                               input string nome);
    esperado_t x;
    botao_carregar = c;
    botao_pausa    = p;
    habilitar      = h;
    direcao        = d;
    x.valor = {sel, t, pa, dir_exp};
    x.nome  = nome;
    fila.push_back(x);
  endtask

  task automatic checkOutput();
    esperado_t x;
    @(posedge clk);
    #1;
    if (fila.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty observed no entry expected one entry");
    end else begin
      x = fila.pop_front();
      comparar(x.valor, x.nome);
    end
  endtask

  task automatic ciclo(input logic c, input logic p, input logic h, input logic d,
                       input logic [1:0] sel, input logic t, input logic pa,
                       input string nome);
    applyStimulus(c, p, h, d, sel, t, pa, nome);
    checkOutput();
  endtask

  initial begin
    rst_n              = 1'b0;
    botao_carregar     = 1'b0;
    botao_pausa        = 1'b0;
    habilitar          = 1'b0;
    direcao            = 1'b0;
    estado_registrador = '0;
    dir_exp            = 1'b0;

    @(posedge clk);
    #1;
    comparar({MANTER, 1'b0, 1'b0, 1'b0}, "reset_inicial");
    rst_n = 1'b1;

    // Load press held: one CARREGA cycle only.
    ciclo(1, 0, 0, 0, CARGA, 0, 0, "carga_inicio");
    for (int i = 1; i < 5; i++) ciclo(1, 0, 0, 0, MANTER, 0, 0, "carga_mantida");
    ciclo(0, 0, 0, 0, MANTER, 0, 0, "carga_solta");

    // Running: first tick DIV cycles after entry, then every DIV cycles.
    ciclo(0, 0, 1, 0, MANTER, 0, 0, "entra_desloca");
    for (int k = 1; k <= 2 * DIV; k++)
      ciclo(0, 0, 1, 0, (k % DIV == 0) ? ESQ_DIR : MANTER, logic'(k % DIV == 0), 0, "desloca_esq");
    dir_exp = SEGUE ? 1'b1 : 1'b0;
    for (int k = 1; k <= 2 * DIV; k++)
      ciclo(0, 0, 1, 1, (k % DIV == 0) ? sel_tick(dir_exp) : MANTER, logic'(k % DIV == 0), 0, "desloca_dir");

    // Pause mid-period, then resume with the count preserved.
    ciclo(0, 0, 1, 1, MANTER, 0, 0, "antes_pausa");
    ciclo(0, 1, 1, 1, MANTER, 0, 1, "pausa");
    for (int i = 0; i < 20; i++) ciclo(0, 0, 1, 1, MANTER, 0, 1, "pausado");
    dir_exp = 1'b1;
    ciclo(0, 1, 1, 1, MANTER, 0, 0, "retoma");
    ciclo(0, 0, 1, 1, MANTER, 0, 0, "retoma_c2");
    ciclo(0, 0, 1, 1, MANTER, 0, 0, "retoma_c3");
    ciclo(0, 0, 1, 1, DIR_ESQ, 1, 0, "retoma_tick");

    // Load and pause together: load wins, pause discarded.
    ciclo(1, 1, 1, 1, CARGA, 0, 0, "carga_e_pausa");
    ciclo(0, 0, 1, 1, MANTER, 0, 0, "apos_carga");
    for (int k = 1; k <= DIV; k++)
      ciclo(0, 0, 1, 1, (k == DIV) ? DIR_ESQ : MANTER, logic'(k == DIV), 0, "desloca_pos_carga");

    // Pause on the wrap edge suppresses that shift; resume fires it next cycle.
    for (int k = 1; k < DIV; k++) ciclo(0, 0, 1, 1, MANTER, 0, 0, "conta_ate_wrap");
    ciclo(0, 1, 1, 1, MANTER, 0, 1, "pausa_no_tick");
    ciclo(0, 0, 1, 1, MANTER, 0, 1, "pausa_mantem");
    ciclo(0, 1, 1, 1, MANTER, 0, 0, "retoma_no_tick");
    ciclo(0, 0, 1, 1, DIR_ESQ, 1, 0, "tick_apos_retoma");

    ciclo(0, 0, 0, 1, MANTER, 0, 0, "desabilita");
    ciclo(0, 0, 0, 1, MANTER, 0, 0, "parado");

`ifdef AUTO_REVERSE_EN
    dir_exp = 1'b0;
    ciclo(0, 0, 1, 0, MANTER, 0, 0, "auto_entra");
    for (int k = 1; k < DIV; k++) ciclo(0, 0, 1, 0, MANTER, 0, 0, "auto_conta");
    estado_registrador = 8'h01;
    dir_exp = 1'b1;
    ciclo(0, 0, 1, 0, DIR_ESQ, 1, 0, "auto_fim_zero");
    estado_registrador = 8'h80;
    for (int k = 1; k < DIV; k++) ciclo(0, 0, 1, 0, MANTER, 0, 0, "auto_conta_dir");
    dir_exp = 1'b0;
    ciclo(0, 0, 1, 0, ESQ_DIR, 1, 0, "auto_fim_topo");
    estado_registrador = 8'h00;
    for (int k = 1; k <= DIV; k++)
      ciclo(0, 0, 1, 0, (k == DIV) ? ESQ_DIR : MANTER, logic'(k == DIV), 0, "auto_zero");
    ciclo(0, 0, 0, 0, MANTER, 0, 0, "auto_para");
`endif

    // Asynchronous reset in the middle of a shift cycle.
    dir_exp = 1'b1;
    ciclo(0, 0, 1, 1, MANTER, 0, 0, "entra_reset");
    for (int k = 1; k < DIV; k++) ciclo(0, 0, 1, 1, MANTER, 0, 0, "conta_reset");
    ciclo(0, 0, 1, 1, DIR_ESQ, 1, 0, "tick_antes_reset");
    rst_n = 1'b0;
    #1;
    comparar({MANTER, 1'b0, 1'b0, 1'b0}, "reset_imediato");
    habilitar = 1'b0;
    direcao   = 1'b0;
    @(posedge clk);
    #1;
    comparar({MANTER, 1'b0, 1'b0, 1'b0}, "reset_mantido");
    rst_n   = 1'b1;
    dir_exp = 1'b0;
    ciclo(0, 0, 0, 0, MANTER, 0, 0, "apos_reset");
    ciclo(1, 0, 0, 0, CARGA, 0, 0, "carga_apos_reset");
    ciclo(0, 0, 0, 0, MANTER, 0, 0, "parado_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
